// File: rtl/fp32_addsub_sequencer_if.sv
// Handshake and data bundle between the operand source, the add/sub sequencer
// and the result writeback stage.
interface fp32_addsub_sequencer_if;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_fpNumberA;
    logic [31:0] io_fpNumberB;
    logic [1:0]  io_operation;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_result;
    logic [3:0]  io_flags;
    logic        io_busy;

    modport master (
        output io_in_valid, io_fpNumberA, io_fpNumberB, io_operation, io_out_ready,
        input  io_in_ready, io_out_valid, io_result, io_flags, io_busy
    );

    modport slave (
        input  io_in_valid, io_fpNumberA, io_fpNumberB, io_operation, io_out_ready,
        output io_in_ready, io_out_valid, io_result, io_flags, io_busy
    );
endinterface

// File: rtl/fp32_addsub_sequencer.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer: one shift or
// add step per cycle through unpack, align, add, normalise and pack.
module fp32_addsub_sequencer #(
    parameter int ALIGN_LIMIT = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    fp32_addsub_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [7:0]  ALIGN_LIMIT_W  = 8'(ALIGN_LIMIT);
    localparam logic [31:0] QNAN           = 32'h7FC0_0000;
    localparam logic [3:0]  FLAG_INVALID   = 4'b1000;
    localparam logic [3:0]  FLAG_OVERFLOW  = 4'b0100;
    localparam logic [3:0]  FLAG_UNDERFLOW = 4'b0011;
    localparam logic [3:0]  FLAG_ZERO      = 4'b0001;

    state_t      state, state_next;
    logic [31:0] op_a, op_a_next, op_b, op_b_next;
    logic [1:0]  op_code, op_code_next;
    logic        sign_p, sign_p_next, sign_s, sign_s_next;
    logic [7:0]  exp_p, exp_p_next, diff, diff_next;
    logic [23:0] mant_s, mant_s_next;
    logic [24:0] acc, acc_next;
    logic [31:0] result, result_next;
    logic [3:0]  flags, flags_next;

    logic [7:0]  exp_a, exp_b, exp_diff, exp_inc, exp_dec;
    logic [22:0] frac_a, frac_b, frac_right;
    logic        sign_a, sign_b_eff, a_primary;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [24:0] sum, acc_left;

    assign exp_a      = op_a[30:23];
    assign exp_b      = op_b[30:23];
    assign frac_a     = op_a[22:0];
    assign frac_b     = op_b[22:0];
    assign sign_a     = op_a[31];
    assign sign_b_eff = op_b[31] ^ op_code[0];
    assign a_zero     = (exp_a == 8'd0);
    assign b_zero     = (exp_b == 8'd0);
    assign a_inf      = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign b_inf      = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign a_nan      = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign b_nan      = (exp_b == 8'hFF) && (frac_b != 23'd0);

    // For normal operands the packed magnitude orders by exponent, then mantissa.
    assign a_primary  = (op_a[30:0] >= op_b[30:0]);
    assign exp_diff   = a_primary ? (exp_a - exp_b) : (exp_b - exp_a);

    // acc holds the primary mantissa until ADD, then the running sum during NORM.
    assign sum        = (sign_p == sign_s) ? (acc + {1'b0, mant_s}) : (acc - {1'b0, mant_s});
    assign acc_left   = acc << 1;
    assign frac_right = acc[23:1];
    assign exp_inc    = exp_p + 8'd1;
    assign exp_dec    = exp_p - 8'd1;

    always_comb begin
        state_next   = state;
        op_a_next    = op_a;
        op_b_next    = op_b;
        op_code_next = op_code;
        sign_p_next  = sign_p;
        sign_s_next  = sign_s;
        exp_p_next   = exp_p;
        diff_next    = diff;
        mant_s_next  = mant_s;
        acc_next     = acc;
        result_next  = result;
        flags_next   = flags;

        case (state)
            IDLE: begin
                if (bus.io_in_valid) begin
                    op_a_next    = bus.io_fpNumberA;
                    op_b_next    = bus.io_fpNumberB;
                    op_code_next = bus.io_operation;
                    state_next   = UNPACK;
                end
            end

            UNPACK: begin
                state_next = DONE;
                flags_next = 4'd0;
                if (op_code[1]) begin
                    result_next = 32'd0;
                    flags_next  = FLAG_INVALID;
                end else if (a_nan || b_nan) begin
                    result_next = QNAN;
                    flags_next  = FLAG_INVALID;
                end else if (a_inf && b_inf) begin
                    if (sign_a != sign_b_eff) begin
                        result_next = QNAN;
                        flags_next  = FLAG_INVALID;
                    end else begin
                        result_next = {sign_a, 8'hFF, 23'd0};
                    end
                end else if (a_inf) begin
                    result_next = {sign_a, 8'hFF, 23'd0};
                end else if (b_inf) begin
                    result_next = {sign_b_eff, 8'hFF, 23'd0};
                end else if (a_zero && b_zero) begin
                    result_next = {sign_a & sign_b_eff, 31'd0};
                    flags_next  = FLAG_ZERO;
                end else if (a_zero) begin
                    result_next = {sign_b_eff, op_b[30:0]};
                end else if (b_zero) begin
                    result_next = op_a;
                end else begin
                    sign_p_next = a_primary ? sign_a : sign_b_eff;
                    sign_s_next = a_primary ? sign_b_eff : sign_a;
                    exp_p_next  = a_primary ? exp_a : exp_b;
                    acc_next    = a_primary ? {2'b01, frac_a} : {2'b01, frac_b};
                    mant_s_next = a_primary ? {1'b1, frac_b} : {1'b1, frac_a};
                    diff_next   = exp_diff;
                    state_next  = (exp_diff == 8'd0) ? ADD : ALIGN;
                end
            end

            ALIGN: begin
                // Large gaps shift everything out anyway, so collapse them to one cycle.
                if (diff > ALIGN_LIMIT_W) begin
                    mant_s_next = 24'd0;
                    diff_next   = 8'd0;
                    state_next  = ADD;
                end else begin
                    mant_s_next = mant_s >> 1;
                    diff_next   = diff - 8'd1;
                    if (diff == 8'd1) begin
                        state_next = ADD;
                    end
                end
            end

            ADD: begin
                acc_next = sum;
                if (sum == 25'd0) begin
                    result_next = 32'd0;
                    flags_next  = FLAG_ZERO;
                    state_next  = DONE;
                end else begin
                    state_next  = NORM;
                end
            end

            NORM: begin
                if (acc[24]) begin
                    if (exp_inc == 8'hFF) begin
                        result_next = {sign_p, 8'hFF, 23'd0};
                        flags_next  = FLAG_OVERFLOW;
                    end else begin
                        result_next = {sign_p, exp_inc, frac_right};
                        flags_next  = 4'd0;
                    end
                    state_next = DONE;
                end else if (!acc[23]) begin
                    if (exp_dec == 8'd0) begin
                        result_next = {sign_p, 31'd0};
                        flags_next  = FLAG_UNDERFLOW;
                        state_next  = DONE;
                    end else begin
                        acc_next   = acc_left;
                        exp_p_next = exp_dec;
                        if (acc_left[23]) begin
                            result_next = {sign_p, exp_dec, acc_left[22:0]};
                            flags_next  = 4'd0;
                            state_next  = DONE;
                        end
                    end
                end else begin
                    result_next = {sign_p, exp_p, acc[22:0]};
                    flags_next  = 4'd0;
                    state_next  = DONE;
                end
            end

            DONE: begin
                if (bus.io_out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_code <= 2'd0;
            sign_p  <= 1'b0;
            sign_s  <= 1'b0;
            exp_p   <= 8'd0;
            diff    <= 8'd0;
            mant_s  <= 24'd0;
            acc     <= 25'd0;
            result  <= 32'd0;
            flags   <= 4'd0;
        end else begin
            state   <= state_next;
            op_a    <= op_a_next;
            op_b    <= op_b_next;
            op_code <= op_code_next;
            sign_p  <= sign_p_next;
            sign_s  <= sign_s_next;
            exp_p   <= exp_p_next;
            diff    <= diff_next;
            mant_s  <= mant_s_next;
            acc     <= acc_next;
            result  <= result_next;
            flags   <= flags_next;
        end
    end

    assign bus.io_in_ready  = (state == IDLE);
    assign bus.io_out_valid = (state == DONE);
    assign bus.io_busy      = (state != IDLE);
    assign bus.io_result    = result;
    assign bus.io_flags     = flags;
endmodule

// File: tb/tb_fp32_addsub_sequencer.sv
// Bench for fp32_addsub_sequencer: directed cases plus random operands checked
// against an arithmetic reference model, including latency and handshake.
module tb_fp32_addsub_sequencer;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rndA, rndB, refRes;
    logic [3:0]  refFl;
    logic [1:0]  rndOp;
    int          refLat;

    fp32_addsub_sequencer_if bus();

    fp32_addsub_sequencer #(.ALIGN_LIMIT(24)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic on magnitudes, latency from the cycle rules.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                     output logic [31:0] res, output logic [3:0] fl, output int lat);
        int ea, eb, ep, es, d, al, k, ma, mb, mp, ms, s;
        logic sa, sb, sp, ss;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (1 << 23) + int'(a[22:0]);
        mb = (1 << 23) + int'(b[22:0]);
        sa = a[31];
        sb = b[31] ^ op[0];
        res = 32'd0;
        fl = 4'd0;
        lat = 2;
        if (op[1]) begin
            fl = 4'b1000;
        end else if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
            res = 32'h7FC00000; fl = 4'b1000;
        end else if (ea == 255 && eb == 255) begin
            if (sa != sb) begin res = 32'h7FC00000; fl = 4'b1000; end
            else res = {sa, 8'hFF, 23'd0};
        end else if (ea == 255) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (eb == 255) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (ea == 0 && eb == 0) begin
            res = {sa & sb, 31'd0}; fl = 4'b0001;
        end else if (ea == 0) begin
            res = {sb, b[30:0]};
        end else if (eb == 0) begin
            res = a;
        end else begin
            if (ea > eb || (ea == eb && ma >= mb)) begin
                ep = ea; mp = ma; sp = sa; es = eb; ms = mb; ss = sb;
            end else begin
                ep = eb; mp = mb; sp = sb; es = ea; ms = ma; ss = sa;
            end
            d  = ep - es;
            al = (d == 0) ? 0 : ((d > 24) ? 1 : d);
            ms = (d > 24) ? 0 : (ms >> d);
            s  = (sp == ss) ? (mp + ms) : (mp - ms);
            if (s == 0) begin
                fl = 4'b0001; lat = 3 + al;
            end else if (s >= (1 << 24)) begin
                lat = 4 + al;
                if (ep + 1 == 255) begin res = {sp, 8'hFF, 23'd0}; fl = 4'b0100; end
                else res = {sp, 8'(ep + 1), 23'(s >> 1)};
            end else begin
                k = 0;
                while ((s << k) < (1 << 23)) k++;
                if (k == 0) begin
                    res = {sp, 8'(ep), 23'(s)}; lat = 4 + al;
                end else if (k >= ep) begin
                    res = {sp, 31'd0}; fl = 4'b0011; lat = 3 + al + ep;
                end else begin
                    res = {sp, 8'(ep - k), 23'(s << k)}; lat = 3 + al + k;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input int hold,
                                 input logic [31:0] expRes, input logic [3:0] expFl, input int expLat);
        int  cycles;
        bit  seen;
        @(negedge clock);
        bus.io_in_valid  = 1'b1;
        bus.io_fpNumberA = a;
        bus.io_fpNumberB = b;
        bus.io_operation = op;
        @(posedge clock);
        @(negedge clock);
        bus.io_in_valid  = 1'b0;
        bus.io_fpNumberA = $urandom;
        bus.io_fpNumberB = $urandom;
        cycles = 1;
        seen   = 1'b0;
        while (!seen && cycles <= 200) begin
            if (bus.io_out_valid) seen = 1'b1;
            else begin
                @(negedge clock);
                cycles++;
            end
        end
        if (!seen) begin
            checkOutput("timeout", 32'(seen), 32'd1);
            reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            return;
        end
        checkOutput("result", bus.io_result, expRes);
        checkOutput("flags", 32'(bus.io_flags), 32'(expFl));
        checkOutput("latency", cycles, expLat);
        for (int i = 0; i < hold; i++) begin
            bus.io_in_valid  = 1'b1;
            bus.io_fpNumberA = $urandom;
            bus.io_fpNumberB = $urandom;
            @(negedge clock);
            checkOutput("hold_result", bus.io_result, expRes);
            checkOutput("hold_flags", 32'(bus.io_flags), 32'(expFl));
            checkOutput("hold_in_ready", 32'(bus.io_in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(bus.io_out_valid), 32'd1);
        end
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        @(negedge clock);
        bus.io_out_ready = 1'b0;
        checkOutput("release_out_valid", 32'(bus.io_out_valid), 32'd0);
        checkOutput("release_busy", 32'(bus.io_busy), 32'd0);
    endtask

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'd0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2:       v[30:23] = 8'hFF;
            3, 4:    v[30:23] = 8'($urandom_range(1, 4));
            5:       v[30:23] = 8'($urandom_range(250, 254));
            default: v[30:23] = 8'($urandom_range(110, 160));
        endcase
        return v;
    endfunction

    initial begin
        reset            = 1'b0;
        bus.io_in_valid  = 1'b0;
        bus.io_fpNumberA = 32'd0;
        bus.io_fpNumberB = 32'd0;
        bus.io_operation = 2'd0;
        bus.io_out_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_in_ready", 32'(bus.io_in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.io_out_valid), 32'd0);
        checkOutput("reset_result", bus.io_result, 32'd0);
        checkOutput("reset_flags", 32'(bus.io_flags), 32'd0);
        checkOutput("reset_busy", 32'(bus.io_busy), 32'd0);
        reset = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h40000000, 4'b0000, 4);
        applyStimulus(32'h40400000, 32'h3F800000, 2'b00, 0, 32'h40800000, 4'b0000, 5);
        applyStimulus(32'h3FC00000, 32'h3F800000, 2'b01, 0, 32'h3F000000, 4'b0000, 4);
        applyStimulus(32'h7F800000, 32'h7F800000, 2'b01, 0, 32'h7FC00000, 4'b1000, 2);
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b11, 0, 32'h00000000, 4'b1000, 2);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 0, 32'h7F800000, 4'b0100, 4);
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b01, 0, 32'h00000000, 4'b0001, 3);
        applyStimulus(32'h4B800000, 32'h3F800000, 2'b00, 0, 32'h4B800000, 4'b0000, 28);
        applyStimulus(32'h4E800000, 32'h3F800000, 2'b00, 0, 32'h4E800000, 4'b0000, 5);
        applyStimulus(32'h00800000, 32'h00C00000, 2'b01, 0, 32'h80000000, 4'b0011, 4);
        applyStimulus(32'h80000000, 32'h80000000, 2'b00, 0, 32'h80000000, 4'b0001, 2);
        applyStimulus(32'h40400000, 32'h3F800000, 2'b00, 5, 32'h40800000, 4'b0000, 5);

        $display("[TB] reset during ALIGN");
        @(negedge clock);
        bus.io_in_valid  = 1'b1;
        bus.io_fpNumberA = 32'h4B800000;
        bus.io_fpNumberB = 32'h3F800000;
        bus.io_operation = 2'b00;
        @(posedge clock);
        @(negedge clock);
        bus.io_in_valid = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("align_busy", 32'(bus.io_busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_busy", 32'(bus.io_busy), 32'd0);
        checkOutput("abort_out_valid", 32'(bus.io_out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.io_in_ready), 32'd1);
        checkOutput("abort_result", bus.io_result, 32'd0);
        checkOutput("abort_flags", 32'(bus.io_flags), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("post_abort_out_valid", 32'(bus.io_out_valid), 32'd0);
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b00, 0, 32'h40000000, 4'b0000, 4);

        $display("[TB] random cases");
        for (int n = 0; n < 300; n++) begin
            rndA = randOperand();
            rndB = randOperand();
            if ($urandom_range(0, 3) == 0) begin
                rndB = {1'($urandom), rndA[30:4], 4'($urandom)};
            end
            rndOp = ($urandom_range(0, 9) == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
            refModel(rndA, rndB, rndOp, refRes, refFl, refLat);
            applyStimulus(rndA, rndB, rndOp, $urandom_range(0, 2), refRes, refFl, refLat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
